// File: rtl/apb_crc_feeder_pkg.sv
// Shared definitions for the APB CRC feeder.
//   state_t            : sequencing FSM states
//   DEF_*_OFFSET       : default register offsets inside the CRC slave
//   CTRL_INIT          : CTRL value that re-initialises the CRC
//   STRB_ALL           : full-word byte strobe
package apb_crc_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT,
        S_WRITE,
        S_READ,
        S_RESULT
    } state_t;

    localparam logic [31:0] DEF_CTRL_OFFSET   = 32'h0;
    localparam logic [31:0] DEF_DATA_OFFSET   = 32'h4;
    localparam logic [31:0] DEF_RESULT_OFFSET = 32'h8;

    localparam logic [31:0] CTRL_INIT = 32'h1;
    localparam logic [3:0]  STRB_ALL  = 4'hF;

endpackage

// File: rtl/apb_crc_feeder_if.sv
// APB4 bus between the feeder (master) and the CRC peripheral (slave).
//   paddr/pwdata/pstrb/pwrite/psel/penable : request, driven by master
//   prdata/pready/pslverr                  : response, driven by slave
interface apb_crc_feeder_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [3:0]            pstrb;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, pwdata, pstrb, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pstrb, pwrite, psel, penable,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_master_xfer.sv
// Single-transfer APB4 engine.
//   start/addr/wdata/strb/write : request; sampled on the cycle start=1,
//                                 issued as SETUP on the following cycle
//   done/rdata/slverr           : completion; done=1 on the ACCESS cycle
//                                 with pready=1, rdata/slverr valid then
//   bus                         : APB4 master side
// start may be asserted together with done to chain transfers with psel
// held high; it must not be asserted while a transfer is still pending.
module apb_master_xfer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            strb,
    input  logic                  write,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  slverr,
    apb_crc_feeder_if.master      bus
);

    assign done   = bus.psel & bus.penable & bus.pready;
    assign rdata  = bus.prdata;
    assign slverr = bus.pslverr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.paddr   <= '0;
            bus.pwdata  <= '0;
            bus.pstrb   <= '0;
        end else if (start) begin
            bus.psel    <= 1'b1;
            bus.penable <= 1'b0;
            bus.pwrite  <= write;
            bus.paddr   <= addr;
            bus.pwdata  <= wdata;
            bus.pstrb   <= strb;
        end else if (bus.psel && !bus.penable) begin
            bus.penable <= 1'b1;
        end else if (done) begin
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
        end
    end

endmodule

// File: rtl/apb_crc_feeder.sv
// APB4 master feeding a word stream into the CRC peripheral.
// Per frame: CTRL write (re-init), one DATA write per stream word, RESULT
// read, then the value is offered on the crc_* handshake.
//   clk, rst                        : clock, async active-high reset
//   s_tdata/s_tstrb/s_tlast/s_tvalid/s_tready : input word stream
//   m                               : APB4 master bus to the CRC slave
//   crc_data/crc_err/crc_valid/crc_ready      : result handshake
module apb_crc_feeder
    import apb_crc_feeder_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter logic [ADDR_WIDTH-1:0] CTRL_OFFSET   = ADDR_WIDTH'(DEF_CTRL_OFFSET),
    parameter logic [ADDR_WIDTH-1:0] DATA_OFFSET   = ADDR_WIDTH'(DEF_DATA_OFFSET),
    parameter logic [ADDR_WIDTH-1:0] RESULT_OFFSET = ADDR_WIDTH'(DEF_RESULT_OFFSET)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [3:0]            s_tstrb,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    apb_crc_feeder_if.master      m,
    output logic [DATA_WIDTH-1:0] crc_data,
    output logic                  crc_err,
    output logic                  crc_valid,
    input  logic                  crc_ready
);

    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFFSET;
    localparam logic [ADDR_WIDTH-1:0] DATA_ADDR   = BASE_ADDR + DATA_OFFSET;
    localparam logic [ADDR_WIDTH-1:0] RESULT_ADDR = BASE_ADDR + RESULT_OFFSET;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] tdata;
    logic [3:0]            tstrb;
    logic                  tlast;
    logic                  err_flag;

    logic                  start;
    logic [ADDR_WIDTH-1:0] x_addr;
    logic [DATA_WIDTH-1:0] x_wdata;
    logic [3:0]            x_strb;
    logic                  x_write;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  slverr;

    logic                  accept;

    assign s_tready  = (state == S_IDLE) || (state == S_WAIT);
    assign accept    = s_tvalid && s_tready;
    assign crc_valid = (state == S_RESULT);
    assign crc_err   = crc_valid && err_flag;

    apb_master_xfer #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_xfer (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .addr   (x_addr),
        .wdata  (x_wdata),
        .strb   (x_strb),
        .write  (x_write),
        .done   (done),
        .rdata  (rdata),
        .slverr (slverr),
        .bus    (m)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each transfer is launched on the cycle the FSM moves into its state,
    // so a completing transfer and the next SETUP are back to back.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        x_addr     = CTRL_ADDR;
        x_wdata    = DATA_WIDTH'(CTRL_INIT);
        x_strb     = STRB_ALL;
        x_write    = 1'b1;
        case (state)
            S_IDLE: begin
                if (s_tvalid) begin
                    state_next = S_INIT;
                    start      = 1'b1;
                end
            end
            S_INIT: begin
                if (done) begin
                    state_next = S_WRITE;
                    start      = 1'b1;
                    x_addr     = DATA_ADDR;
                    x_wdata    = tdata;
                    x_strb     = tstrb;
                end
            end
            S_WAIT: begin
                // The beat lands in the holding register on this same edge,
                // so the request is taken straight from the stream.
                if (s_tvalid) begin
                    state_next = S_WRITE;
                    start      = 1'b1;
                    x_addr     = DATA_ADDR;
                    x_wdata    = s_tdata;
                    x_strb     = s_tstrb;
                end
            end
            S_WRITE: begin
                if (done) begin
                    if (tlast) begin
                        state_next = S_READ;
                        start      = 1'b1;
                        x_addr     = RESULT_ADDR;
                        x_wdata    = '0;
                        x_strb     = '0;
                        x_write    = 1'b0;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_READ: begin
                if (done) begin
                    state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (crc_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata <= '0;
            tstrb <= '0;
            tlast <= 1'b0;
        end else if (accept) begin
            tdata <= s_tdata;
            tstrb <= s_tstrb;
            tlast <= s_tlast;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
        end else if (state == S_RESULT && crc_ready) begin
            err_flag <= 1'b0;
        end else if (done && slverr) begin
            err_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_data <= '0;
        end else if (state == S_READ && done) begin
            crc_data <= rdata;
        end
    end

endmodule

// File: tb/tb_apb_crc_feeder.sv
// Self-checking bench for apb_crc_feeder: APB slave model, frame-level
// reference model and directed plus randomized frames.
module tb_apb_crc_feeder;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } xfer_t;

    typedef enum {M_READY, M_BUSY, M_RESULT} mode_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] crc_data;
    logic        crc_err;
    logic        crc_valid;
    logic        crc_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // stimulus-owned knobs
    int          waits = 0;
    int          err_abs = -1;
    logic [31:0] result_val = '0;
    int          acc_cyc = 0;
    logic [31:0] bd[$];
    logic [3:0]  bs[$];

    // slave-owned
    int setup_count = 0;
    int err_count = 0;
    int wait_left = 0;

    // model/monitor-owned
    mode_t       mode = M_READY;
    mode_t       busy_next = M_READY;
    int          busy_until = 0;
    logic        first_beat = 1'b1;
    int          err_base = 0;
    logic [31:0] exp_data = '0;
    logic        exp_err = 1'b0;
    xfer_t       exp_q[$];
    xfer_t       obs_log[$];
    xfer_t       su;
    int          setup_cyc = 0;
    int          last_dur = 0;

    apb_crc_feeder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    apb_crc_feeder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .BASE_ADDR(32'h0),
        .CTRL_OFFSET(32'h0),
        .DATA_OFFSET(32'h4),
        .RESULT_OFFSET(32'h8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tstrb   (s_tstrb),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m         (bus),
        .crc_data  (crc_data),
        .crc_err   (crc_err),
        .crc_valid (crc_valid),
        .crc_ready (crc_ready)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // APB slave: fixed wait states per transfer, RESULT value on every
    // completion, optional slverr on one chosen transfer.
    always @(posedge clk) begin
        #1;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = $urandom;
        if (!rst && bus.psel) begin
            if (!bus.penable) begin
                wait_left = waits;
                setup_count++;
            end else if (wait_left > 0) begin
                wait_left--;
            end else begin
                bus.pready = 1'b1;
                bus.prdata = result_val;
                if (setup_count == err_abs) begin
                    bus.pslverr = 1'b1;
                    err_count++;
                end
            end
        end
    end

    // Reference model and compare process.
    always @(negedge clk) begin
        xfer_t e, o;
        int    ntr, dur;
        if (rst) begin
            chk("rst_psel", bus.psel, 0);
            chk("rst_penable", bus.penable, 0);
            chk("rst_pwrite", bus.pwrite, 0);
            chk("rst_paddr", bus.paddr, 0);
            chk("rst_pwdata", bus.pwdata, 0);
            chk("rst_pstrb", bus.pstrb, 0);
            chk("rst_crc_valid", crc_valid, 0);
            chk("rst_crc_err", crc_err, 0);
            chk("rst_crc_data", crc_data, 0);
            chk("rst_s_tready", s_tready, 1);
            mode = M_READY;
            first_beat = 1'b1;
            exp_q.delete();
        end else begin
            if (mode == M_BUSY && cyc == busy_until) begin
                mode = busy_next;
                if (mode == M_RESULT) begin
                    exp_data = result_val;
                    exp_err  = (err_count != err_base);
                end
            end
            case (mode)
                M_READY: begin
                    chk("s_tready", s_tready, 1);
                    chk("crc_valid", crc_valid, 0);
                    chk("psel_idle", bus.psel, 0);
                    if (s_tvalid) begin
                        ntr = 1;
                        if (first_beat) begin
                            exp_q.push_back('{1'b1, 32'h0, 32'h1, 4'hF});
                            err_base = err_count;
                            ntr++;
                        end
                        exp_q.push_back('{1'b1, 32'h4, s_tdata, s_tstrb});
                        if (s_tlast) begin
                            exp_q.push_back('{1'b0, 32'h8, 32'h0, 4'h0});
                            ntr++;
                        end
                        busy_until = cyc + ntr * (waits + 2) + 1;
                        busy_next  = s_tlast ? M_RESULT : M_READY;
                        first_beat = s_tlast;
                        mode = M_BUSY;
                    end
                end
                M_BUSY: begin
                    chk("s_tready_busy", s_tready, 0);
                    chk("crc_valid_busy", crc_valid, 0);
                    chk("psel_busy", bus.psel, 1);
                end
                default: begin
                    chk("crc_valid_res", crc_valid, 1);
                    chk("s_tready_res", s_tready, 0);
                    chk("psel_res", bus.psel, 0);
                    chk("crc_data", crc_data, exp_data);
                    chk("crc_err", crc_err, exp_err);
                    if (crc_ready) mode = M_READY;
                end
            endcase

            o = '{bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb};
            if (bus.psel && !bus.penable) begin
                su = o;
                setup_cyc = cyc;
            end else if (bus.psel && bus.penable) begin
                chk("hold_paddr", o.addr, su.addr);
                chk("hold_pwdata", o.wdata, su.wdata);
                chk("hold_pwrite_pstrb", {o.write, o.strb}, {su.write, su.strb});
                if (bus.pready) begin
                    dur = cyc - setup_cyc + 1;
                    last_dur = dur;
                    chk("xfer_len", dur, waits + 2);
                    if (exp_q.size() == 0) begin
                        chk("apb_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("apb_pwrite", o.write, e.write);
                        chk("apb_paddr", o.addr, e.addr);
                        chk("apb_pstrb", o.strb, e.strb);
                        if (e.write) chk("apb_pwdata", o.wdata, e.wdata);
                    end
                    obs_log.push_back(o);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called in the posedge+1 phase; returns in the posedge+1 phase.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] st,
                             input logic l, input int gap);
        logic acc = 1'b0;
        int   n = 0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        s_tdata = d;
        s_tstrb = st;
        s_tlast = l;
        s_tvalid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            if (s_tready) begin
                acc = 1'b1;
                acc_cyc = cyc;
            end
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tdata = $urandom;
        s_tstrb = 4'($urandom);
        s_tlast = 1'($urandom);
    endtask

    // rdelay < 0: crc_ready already high when the result appears.
    task automatic get_result(input int rdelay, output logic [31:0] d,
                              output logic e, output int lat);
        logic seen = 1'b0;
        int   n = 0;
        d = '0;
        e = 1'b0;
        lat = 0;
        if (rdelay < 0) crc_ready = 1'b1;
        while (!seen && n < 300) begin
            @(negedge clk);
            if (crc_valid) begin
                seen = 1'b1;
                d = crc_data;
                e = crc_err;
                lat = cyc - acc_cyc;
            end
            n++;
        end
        if (!seen) chk("result_timeout", 0, 1);
        if (rdelay >= 0) begin
            repeat (rdelay) @(posedge clk);
            @(posedge clk);
            #1;
            crc_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        crc_ready = 1'b0;
    endtask

    task automatic run_frame(input int w, input int ex, input logic [31:0] res,
                             input int gap_max, input int rdelay,
                             output logic [31:0] d, output logic e, output int lat);
        waits = w;
        result_val = res;
        err_abs = (ex < 0) ? -1 : setup_count + ex + 1;
        for (int i = 0; i < bd.size(); i++)
            send_beat(bd[i], bs[i], (i == bd.size() - 1), $urandom_range(gap_max, 0));
        get_result(rdelay, d, e, lat);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat, base, n, nb, ex;
        logic        found;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 3-word frame, zero wait states
        bd = '{32'h11111111, 32'h22222222, 32'h33333333};
        bs = '{4'hF, 4'hF, 4'hF};
        base = obs_log.size();
        run_frame(0, -1, 32'hCBF43926, 0, 0, d, e, lat);
        chk("t1_nxfers", obs_log.size() - base, 5);
        chk("t1_ctrl", {obs_log[base].write, obs_log[base].addr, obs_log[base].wdata[3:0]}, {1'b1, 32'h0, 4'h1});
        chk("t1_w0", obs_log[base+1].wdata, 32'h11111111);
        chk("t1_w1", obs_log[base+2].wdata, 32'h22222222);
        chk("t1_w2", obs_log[base+3].wdata, 32'h33333333);
        chk("t1_read", {obs_log[base+4].write, obs_log[base+4].addr}, {1'b0, 32'h8});
        chk("t1_data", d, 32'hCBF43926);
        chk("t1_err", e, 0);
        chk("t1_latency", lat, 5);

        // single-beat frame with partial strobes
        bd = '{32'hDEADBEEF};
        bs = '{4'b0011};
        base = obs_log.size();
        run_frame(0, -1, 32'h0BADF00D, 0, -1, d, e, lat);
        chk("t2_ctrl_strb", obs_log[base].strb, 4'hF);
        chk("t2_data_strb", obs_log[base+1].strb, 4'b0011);
        chk("t2_data_word", obs_log[base+1].wdata, 32'hDEADBEEF);
        chk("t2_read_strb", obs_log[base+2].strb, 4'h0);
        chk("t2_latency", lat, 7);

        // three wait states on every transfer
        bd = '{32'h01020304, 32'h05060708};
        bs = '{4'hF, 4'hF};
        run_frame(3, -1, 32'h12345678, 0, 0, d, e, lat);
        chk("t3_xfer_len", last_dur, 5);
        chk("t3_latency", lat, 11);

        // slverr on the second DATA write, then a clean frame
        bd = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003};
        bs = '{4'hF, 4'hF, 4'hF};
        run_frame(0, 2, 32'h55AA55AA, 0, 1, d, e, lat);
        chk("t4_err_set", e, 1);
        chk("t4_data", d, 32'h55AA55AA);
        bd = '{32'hBBBB0001, 32'hBBBB0002};
        bs = '{4'hF, 4'hF};
        run_frame(0, -1, 32'h66666666, 0, 0, d, e, lat);
        chk("t4_err_clear", e, 0);

        // result held for 10+ cycles
        bd = '{32'hCCCC0001, 32'hCCCC0002};
        bs = '{4'hF, 4'h5};
        run_frame(1, -1, 32'h77777777, 1, 10, d, e, lat);
        @(negedge clk);
        chk("t5_tready_after_hs", s_tready, 1);
        @(posedge clk);
        #1;

        // reset during the ACCESS phase of a DATA write
        waits = 2;
        err_abs = -1;
        send_beat(32'hA5A5A5A5, 4'hF, 1'b0, 0);
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            if (bus.psel && bus.penable && bus.paddr == 32'h4) found = 1'b1;
            n++;
        end
        if (!found) chk("t6_access_timeout", 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_psel", bus.psel, 0);
        chk("t6_penable", bus.penable, 0);
        chk("t6_paddr", bus.paddr, 0);
        chk("t6_crc_valid", crc_valid, 0);
        chk("t6_s_tready", s_tready, 1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bd = '{32'h99999999};
        bs = '{4'hF};
        base = obs_log.size();
        run_frame(0, -1, 32'h13579BDF, 0, 0, d, e, lat);
        chk("t6_first_is_ctrl", {obs_log[base].write, obs_log[base].addr, obs_log[base].wdata},
            {1'b1, 32'h0, 32'h1});
        chk("t6_data", d, 32'h13579BDF);

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            nb = $urandom_range(5, 1);
            bd.delete();
            bs.delete();
            for (int i = 0; i < nb; i++) begin
                bd.push_back($urandom);
                bs.push_back(4'($urandom));
            end
            ex = ($urandom_range(2, 0) == 0) ? $urandom_range(nb + 1, 0) : -1;
            run_frame($urandom_range(2, 0), ex, $urandom, 2,
                      $urandom_range(4, 0) - 1, d, e, lat);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
